button_conditioner: RTL

//  Parametrised N-channel input front end for the Tetris core: 2-FF sync, per-channel debounce,

---
 rtl/tetris_input_pkg.sv | 18 +
 rtl/button_channel.sv | 116 +++++++++++
 rtl/button_conditioner.sv | 43 ++++
 3 files changed

// File: rtl/tetris_input_pkg.sv
// rtl/tetris_input_pkg.sv - shared channel indices, 50 MHz timing defaults and repeat-FSM states
package tetris_input_pkg;

    localparam int CH_LEFT  = 0;
    localparam int CH_RIGHT = 1;
    localparam int CH_ROT   = 2;

    localparam int DEF_DEBOUNCE_CYC     = 500000;
    localparam int DEF_REPEAT_DELAY_CYC = 12500000;
    localparam int DEF_REPEAT_RATE_CYC  = 2500000;

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        HELD_DELAY  = 2'd1,
        HELD_REPEAT = 2'd2
    } rep_state_e;

endpackage

// File: rtl/button_channel.sv
// rtl/button_channel.sv - one button: 2-FF sync, debounce, press pulse and delayed auto-repeat
module button_channel
    import tetris_input_pkg::*;
#(
    parameter bit ACTIVE_LOW       = 1'b1,
    parameter int DEBOUNCE_CYC     = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DELAY_CYC = DEF_REPEAT_DELAY_CYC,
    parameter int REPEAT_RATE_CYC  = DEF_REPEAT_RATE_CYC,
    parameter bit REPEAT_EN        = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic level_o,
    output logic pulse_o
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam int TMR_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(REPEAT_DELAY_CYC - 1);
    localparam logic [TMR_W-1:0] RATE_LAST  = TMR_W'(REPEAT_RATE_CYC - 1);

    logic             pressed_w;
    logic             sync1_q, sync2_q;
    logic [DB_W-1:0]  cnt_q, cnt_d;
    logic             level_q, level_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             pulse_q, pulse_d;
    rep_state_e       state_q, state_d;

    assign pressed_w = ACTIVE_LOW ? ~raw_i : raw_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            timer_q <= '0;
            pulse_q <= 1'b0;
            state_q <= RELEASED;
        end else begin
            sync1_q <= pressed_w;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            timer_q <= timer_d;
            pulse_q <= pulse_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == DB_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // FSM follows level_d so the press pulse lands in the same cycle level_o first reads 1.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pulse_d = 1'b0;
        case (state_q)
            RELEASED: begin
                timer_d = '0;
                if (level_d) begin
                    state_d = HELD_DELAY;
                    pulse_d = 1'b1;
                end
            end
            HELD_DELAY: begin
                if (!level_d) begin
                    state_d = RELEASED;
                    timer_d = '0;
                end else if (REPEAT_EN) begin
                    if (timer_q == DELAY_LAST) begin
                        state_d = HELD_REPEAT;
                        timer_d = '0;
                        pulse_d = 1'b1;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            HELD_REPEAT: begin
                if (!level_d) begin
                    state_d = RELEASED;
                    timer_d = '0;
                end else if (timer_q == RATE_LAST) begin
                    timer_d = '0;
                    pulse_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = RELEASED;
                timer_d = '0;
            end
        endcase
    end

    assign level_o = level_q;
    assign pulse_o = pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - N-channel button front end with enable-masked action strobes
module button_conditioner
    import tetris_input_pkg::*;
#(
    parameter int              N_CH             = 3,
    parameter bit              ACTIVE_LOW       = 1'b1,
    parameter int              DEBOUNCE_CYC     = DEF_DEBOUNCE_CYC,
    parameter int              REPEAT_DELAY_CYC = DEF_REPEAT_DELAY_CYC,
    parameter int              REPEAT_RATE_CYC  = DEF_REPEAT_RATE_CYC,
    parameter logic [N_CH-1:0] REPEAT_EN        = 3'b011
) (
    input  logic            CLOCK_50,
    input  logic            resetn,
    input  logic [N_CH-1:0] raw_i,
    input  logic            enable_i,
    output logic [N_CH-1:0] level_o,
    output logic [N_CH-1:0] pulse_o,
    output logic            any_pulse_o
);

    logic [N_CH-1:0] ch_pulse_w;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        button_channel #(
            .ACTIVE_LOW      (ACTIVE_LOW),
            .DEBOUNCE_CYC    (DEBOUNCE_CYC),
            .REPEAT_DELAY_CYC(REPEAT_DELAY_CYC),
            .REPEAT_RATE_CYC (REPEAT_RATE_CYC),
            .REPEAT_EN       (REPEAT_EN[i])
        ) u_ch (
            .clk_i  (CLOCK_50),
            .rst_ni (resetn),
            .raw_i  (raw_i[i]),
            .level_o(level_o[i]),
            .pulse_o(ch_pulse_w[i])
        );
    end

    // Masking after the channels keeps the repeat schedule running while disabled.
    assign pulse_o     = ch_pulse_w & {N_CH{enable_i}};
    assign any_pulse_o = |pulse_o;

endmodule
